// File: rtl/fir_pkg.sv
// Shared constants and the saturation helper for the FIR output path.
//   IN_WIDTH_DEF / OUT_WIDTH_DEF : default FIR result and requantised widths
//   SAT_MAX_DEF / SAT_MIN_DEF    : clip limits at the default output width
//   saturate()                   : clip a signed value to a signed w-bit range
package fir_pkg;

    localparam int unsigned IN_WIDTH_DEF  = 18;
    localparam int unsigned OUT_WIDTH_DEF = 8;

    localparam int SAT_MAX_DEF = (2 ** (OUT_WIDTH_DEF - 1)) - 1;
    localparam int SAT_MIN_DEF = -(2 ** (OUT_WIDTH_DEF - 1));

    // Clip v into [-2^(w-1), 2^(w-1)-1]; v is a sign-extended value up to 32 bits.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int unsigned       w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n          : clock, async active-low reset
//   push_i, data_i      : write request and data (ignored when full unless popping)
//   pop_i               : read request (ignored when empty)
//   data_o              : head entry, valid while !empty_o
//   full_o, empty_o     : occupancy flags
//   level_o             : current occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              wr_en_c;
    logic              rd_en_c;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // A full FIFO still takes a write when a read frees the head slot this cycle.
    always_comb begin
        rd_en_c  = pop_i & ~empty_o;
        wr_en_c  = push_i & (~full_o | rd_en_c);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en_c && !rd_en_c) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en_c && rd_en_c) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en_c) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output stage: decimate, round/saturate to OUT_WIDTH, buffer in a FWFT FIFO.
//   clk, rst            : clock, async active-low reset
//   sample_in/_valid    : full-precision FIR result, no backpressure
//   out_data/_valid     : FIFO head and not-empty, consumed with out_ready
//   level               : FIFO occupancy
//   drop_pulse          : a stage-1 sample is being discarded this cycle (FIFO full)
//   sat_sticky          : a kept sample was clipped; cleared by clear_flags
//   ovf_sticky          : a sample was dropped; cleared by clear_flags
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = IN_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int unsigned SHIFT      = 7,
    parameter int unsigned DECIM      = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_WIDTH-1:0]           sample_in,
    input  logic                          sample_valid,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          drop_pulse,
    output logic                          sat_sticky,
    output logic                          ovf_sticky,
    input  logic                          clear_flags
);

    localparam int unsigned TW = IN_WIDTH + 1;
    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    // Half an output LSB; zero when SHIFT is 0 so no rounding is applied.
    localparam logic [TW-1:0] RND = TW'((2 ** SHIFT) / 2);

    logic [PW-1:0]        phase_q, phase_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [OUT_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                 sat_q, sat_d;
    logic                 ovf_q, ovf_d;

    logic                 keep_c;
    logic signed [TW-1:0] t_c;
    logic signed [TW-1:0] q_c;
    logic signed [31:0]   q32_c;
    logic signed [31:0]   qs32_c;
    logic                 sat_c;
    logic                 pop_c;
    logic                 drop_c;
    logic                 fifo_full_c;
    logic                 fifo_empty_c;

    // Decimation phase, rounding and clip detection for the incoming sample.
    always_comb begin
        keep_c = sample_valid & (phase_q == '0);
        phase_d = phase_q;
        if (sample_valid) begin
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end
        t_c    = $signed({sample_in[IN_WIDTH-1], sample_in}) + $signed(RND);
        q_c    = t_c >>> SHIFT;
        q32_c  = 32'(q_c);
        qs32_c = saturate(q32_c, OUT_WIDTH);
        sat_c  = (qs32_c != q32_c);
    end

    // Stage-1 register and sticky flags; a new event beats clear_flags.
    always_comb begin
        pop_c      = out_valid & out_ready;
        drop_c     = s1_valid_q & fifo_full_c & ~pop_c;
        s1_valid_d = keep_c;
        s1_data_d  = keep_c ? OUT_WIDTH'(qs32_c) : s1_data_q;
        sat_d      = (sat_q & ~clear_flags) | (keep_c & sat_c);
        ovf_d      = (ovf_q & ~clear_flags) | drop_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .DATA_W (OUT_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (s1_valid_q),
        .pop_i   (pop_c),
        .data_i  (s1_data_q),
        .data_o  (out_data),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c),
        .level_o (level)
    );

    assign out_valid  = ~fifo_empty_c;
    assign drop_pulse = drop_c;
    assign sat_sticky = sat_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_fir_out_requant.sv
module tb_fir_out_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sample_in;
    logic        sample_valid;
    logic        out_ready;
    logic        clear_flags;

    logic [7:0]  a_data,  b_data;
    logic        a_valid, b_valid;
    logic [2:0]  a_level, b_level;
    logic        a_drop,  b_drop;
    logic        a_sat,   b_sat;
    logic        a_ovf,   b_ovf;

    int tests = 0;
    int fails = 0;
    int drops;

    always #5 clk = ~clk;

    fir_out_requant #(.DECIM(1)) u_a (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready), .level(a_level),
        .drop_pulse(a_drop), .sat_sticky(a_sat), .ovf_sticky(a_ovf), .clear_flags(clear_flags)
    );

    fir_out_requant #(.DECIM(2)) u_b (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready), .level(b_level),
        .drop_pulse(b_drop), .sat_sticky(b_sat), .ovf_sticky(b_ovf), .clear_flags(clear_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(a_valid), 32'(1'b1));
        chk({tag, "_data"}, 32'(a_data), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset;
        sample_valid = 1'b0;
        out_ready    = 1'b0;
        clear_flags  = 1'b0;
        rst          = 1'b0;
        tick();
        rst          = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        out_ready    = 1'b0;
        clear_flags  = 1'b0;

        // Reset state, before any clock edge
        #3;
        chk("rst_valid", 32'(a_valid), 32'(1'b0));
        chk("rst_level", 32'(a_level), 32'(3'd0));
        chk("rst_data",  32'(a_data),  32'(8'h00));
        chk("rst_drop",  32'(a_drop),  32'(1'b0));
        chk("rst_sat",   32'(a_sat),   32'(1'b0));
        chk("rst_ovf",   32'(a_ovf),   32'(1'b0));
        tick();
        rst = 1'b1;

        // 1: rounding half toward +inf
        send(18'(1000));
        send(18'(-64));
        send(18'(-65));
        send(18'(63));
        tick();
        tick();
        chk("t1_level", 32'(a_level), 32'(3'd4));
        chk("t1_sat",   32'(a_sat),   32'(1'b0));
        chk("t1_b_level", 32'(b_level), 32'(3'd2));
        pop_chk("t1_o0", 8'h08);
        pop_chk("t1_o1", 8'h00);
        pop_chk("t1_o2", 8'hFF);
        pop_chk("t1_o3", 8'h00);
        chk("t1_empty", 32'(a_valid), 32'(1'b0));

        // 2: saturation, sticky flag and clear priority
        do_reset();
        send(18'(40000));
        chk("t2_sat_set", 32'(a_sat), 32'(1'b1));
        send(18'(-40000));
        tick();
        pop_chk("t2_o0", 8'h7F);
        pop_chk("t2_o1", 8'h80);
        clear_flags = 1'b1;
        send(18'(-40000));
        clear_flags = 1'b0;
        chk("t2_set_wins", 32'(a_sat), 32'(1'b1));
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t2_cleared", 32'(a_sat), 32'(1'b0));

        // 3: DECIM=2 keeps samples 0 and 2
        do_reset();
        out_ready = 1'b1;
        send(18'(128));
        chk("t3_lat1", 32'(b_valid), 32'(1'b0));
        send(18'(256));
        chk("t3_v0",   32'(b_valid), 32'(1'b1));
        chk("t3_d0",   32'(b_data),  32'(8'h01));
        send(18'(384));
        chk("t3_gap",  32'(b_valid), 32'(1'b0));
        send(18'(512));
        chk("t3_v1",   32'(b_valid), 32'(1'b1));
        chk("t3_d1",   32'(b_data),  32'(8'h03));
        tick();
        tick();
        chk("t3_done_valid", 32'(b_valid), 32'(1'b0));
        chk("t3_done_level", 32'(b_level), 32'(3'd0));

        // 4: overflow drops two samples
        do_reset();
        drops = 0;
        for (int k = 1; k <= 6; k++) begin
            send(18'(128 * k));
            drops += int'(a_drop);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            drops += int'(a_drop);
        end
        chk("t4_drops", 32'(drops),   32'(2));
        chk("t4_level", 32'(a_level), 32'(3'd4));
        chk("t4_ovf",   32'(a_ovf),   32'(1'b1));
        pop_chk("t4_o0", 8'h01);
        pop_chk("t4_o1", 8'h02);
        pop_chk("t4_o2", 8'h03);
        pop_chk("t4_o3", 8'h04);
        chk("t4_empty", 32'(a_valid), 32'(1'b0));

        // 5: full FIFO with simultaneous push and pop
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            send(18'(128 * k));
        end
        tick();
        chk("t5_full", 32'(a_level), 32'(3'd4));
        send(18'(640));
        out_ready = 1'b1;
        #1;
        chk("t5_nodrop", 32'(a_drop), 32'(1'b0));
        tick();
        out_ready = 1'b0;
        chk("t5_level", 32'(a_level), 32'(3'd4));
        chk("t5_ovf",   32'(a_ovf),   32'(1'b0));
        chk("t5_head",  32'(a_data),  32'(8'h02));

        // 6: reset mid-stream
        do_reset();
        send(18'(40000));
        send(18'(256));
        send(18'(384));
        out_ready = 1'b1;
        send(18'(512));
        out_ready = 1'b0;
        send(18'(640));
        chk("t6_pre_level", 32'(a_level), 32'(3'd3));
        chk("t6_pre_sat",   32'(a_sat),   32'(1'b1));
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(a_valid), 32'(1'b0));
        chk("t6_level", 32'(a_level), 32'(3'd0));
        chk("t6_sat",   32'(a_sat),   32'(1'b0));
        chk("t6_ovf",   32'(a_ovf),   32'(1'b0));
        chk("t6_b_level", 32'(b_level), 32'(3'd0));
        rst = 1'b1;
        send(18'(1152));
        tick();
        chk("t6_a_valid", 32'(a_valid), 32'(1'b1));
        chk("t6_a_data",  32'(a_data),  32'(8'h09));
        chk("t6_b_valid", 32'(b_valid), 32'(1'b1));
        chk("t6_b_data",  32'(b_data),  32'(8'h09));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
